alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous squash of all held entries.
REQ-005 in_valid / in_ready  input / output  1 / 1  upstream (decode) handshake; transfer when both are high.
REQ-006 in_rs1_data, in_rs2_data, in_imm, in_pc  input  XLEN each  register-file reads, decoded immediate, instruction PC.
REQ-007 in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  source and destination register indices.
REQ-008 in_alu_ctrl  input  4  ALU operation code, passed through unchanged.
REQ-009 in_use_pc, in_use_imm, in_reg_write  input  1 each  srcA=PC select, srcB=immediate select, writeback enable.
REQ-010 exmem_we, exmem_rd, exmem_data  input  1/5/XLEN  EX/MEM forwarding port.
REQ-011 memwb_we, memwb_rd, memwb_data  input  1/5/XLEN  MEM/WB forwarding port.
REQ-012 out_valid / out_ready  output / input  1 / 1  downstream (ALU/EX) handshake.
REQ-013 srcA, srcB, out_store_data  output  XLEN each  ALU operands and forwarded rs2 value.
REQ-014 alu_ctrl, out_rd_addr, out_reg_write  output  4/5/1  registered control to the ALU and writeback.

Function
REQ-015 Storage SHALL be two entries, main and skid; outputs SHALL be driven only from main-entry registers.
REQ-016 in_ready SHALL equal NOT skid_valid, derived from a register, with no combinational path from out_ready.
REQ-017 Latency SHALL be one cycle: an entry accepted at edge N is presented with out_valid=1 after edge N.
REQ-018 On accept with main empty or main draining (out_ready=1), the entry SHALL load main; otherwise it SHALL load skid.
REQ-019 When main drains and skid is valid, skid SHALL move to main in the same edge, and in_ready SHALL rise the following cycle.
REQ-020 Simultaneous drain and accept with skid valid SHALL be impossible (in_ready=0); with skid empty, main SHALL be replaced, no bubble.
REQ-021 Operand forwarding at capture: rs value = exmem_data if exmem_we and exmem_rd==rs!=0; else memwb_data if memwb_we and memwb_rd==rs!=0; else register data.
REQ-022 Index 0 SHALL never forward; rs value for index 0 SHALL be the register input unchanged.
REQ-023 Any held entry (main not draining, or skid) SHALL be refreshed each cycle from the MEM/WB port under the REQ-021 match rule for both rs1 and rs2.
REQ-024 srcA SHALL be PC when use_pc=1, else forwarded rs1; srcB SHALL be immediate when use_imm=1, else forwarded rs2; out_store_data SHALL always be forwarded rs2.
REQ-025 alu_ctrl codes SHALL pass unchanged, including undefined codes 1010-1111.
REQ-026 flush SHALL clear main_valid and skid_valid at the edge, overriding any simultaneous accept; in_ready SHALL be 1 the next cycle.
REQ-027 out_valid SHALL not drop while out_ready=0 except via flush or reset; output data SHALL be stable while out_valid=1 and out_ready=0, except REQ-023 refresh.

Reset
REQ-028 Asserting rst_n low SHALL, asynchronously and mid-transfer, clear both valids, zero srcA, srcB, out_store_data, alu_ctrl, out_rd_addr, out_reg_write; in_ready SHALL read 1.
REQ-029 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-030 ALU operation encodings (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001) and the stage-entry struct SHALL live in a shared package alu_pkg.
REQ-031 The priority forwarding selector SHALL be one sub-module, fwd_select, instantiated once per source operand.

Verification
REQ-032 Reset then single entry rs1=x5(0x10), rs2=x6(0x20), alu_ctrl=0000, out_ready=1 -> out_valid next cycle, srcA=0x10, srcB=0x20.
REQ-033 exmem rd=x5 data 0xAAAA and memwb rd=x5 data 0xBBBB both active at capture -> srcA=0xAAAA; with rd=x0 both -> srcA is register value.
REQ-034 out_ready=0 for three cycles while two entries offered -> in_ready=0 after the second, out_valid held, no data loss, in-order delivery once out_ready=1.
REQ-035 Entry held in main with rs2=x7; memwb_we rd=x7 data 0x1234 the next cycle -> srcB and out_store_data become 0x1234.
REQ-036 flush asserted with both entries full and in_valid=1 -> out_valid=0 and in_ready=1 next cycle, offered entry dropped.
REQ-037 rst_n low mid-stall, asynchronously between edges -> all outputs zero immediately, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg -- ALU opcode encodings, operand-stage entry type, forwarding match
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Control half of a stage entry; operand data is kept beside it at XLEN.
  typedef struct packed {
    reg_idx_t   rs1_addr;
    reg_idx_t   rs2_addr;
    reg_idx_t   rd_addr;
    logic [3:0] alu_ctrl;
    logic       use_pc;
    logic       use_imm;
    logic       reg_write;
  } stage_ctrl_t;

  // x0 is hardwired to zero, so a write targeting it must never be forwarded.
  function automatic logic fwd_hit(input logic we, input reg_idx_t rd, input reg_idx_t rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_select -- priority operand forwarding: EX/MEM, then MEM/WB, then regfile
// Revision: 1.0
// ---------------------------------------------------------------------------
module fwd_select
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  reg_idx_t         rs_addr_i,
  input  logic [XLEN-1:0]  reg_data_i,
  input  logic             exmem_we_i,
  input  reg_idx_t         exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_data_i,
  input  logic             memwb_we_i,
  input  reg_idx_t         memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic [XLEN-1:0]  data_o
);

  always_comb begin
    data_o = reg_data_i;
    if (fwd_hit(exmem_we_i, exmem_rd_i, rs_addr_i)) begin
      data_o = exmem_data_i;
    end else if (fwd_hit(memwb_we_i, memwb_rd_i, rs_addr_i)) begin
      data_o = memwb_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_stage -- two-entry (main + skid) operand stage with forwarding
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [4:0]       in_rd_addr,
  input  logic [3:0]       in_alu_ctrl,
  input  logic             in_use_pc,
  input  logic             in_use_imm,
  input  logic             in_reg_write,
  input  logic             exmem_we,
  input  logic [4:0]       exmem_rd,
  input  logic [XLEN-1:0]  exmem_data,
  input  logic             memwb_we,
  input  logic [4:0]       memwb_rd,
  input  logic [XLEN-1:0]  memwb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  srcA,
  output logic [XLEN-1:0]  srcB,
  output logic [XLEN-1:0]  out_store_data,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       out_rd_addr,
  output logic             out_reg_write
);

  stage_ctrl_t     w_in_ctrl;
  stage_ctrl_t     main_ctrl_q, main_ctrl_d;
  stage_ctrl_t     skid_ctrl_q, skid_ctrl_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] main_rs1_q, main_rs1_d, main_rs2_q, main_rs2_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, main_pc_q, main_pc_d;
  logic [XLEN-1:0] skid_rs1_q, skid_rs1_d, skid_rs2_q, skid_rs2_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d, skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] w_cap_rs1, w_cap_rs2;
  logic [XLEN-1:0] w_main_rs1_ref, w_main_rs2_ref, w_skid_rs1_ref, w_skid_rs2_ref;
  logic            w_accept, w_drain;

  always_comb begin
    w_in_ctrl           = '0;
    w_in_ctrl.rs1_addr  = in_rs1_addr;
    w_in_ctrl.rs2_addr  = in_rs2_addr;
    w_in_ctrl.rd_addr   = in_rd_addr;
    w_in_ctrl.alu_ctrl  = in_alu_ctrl;
    w_in_ctrl.use_pc    = in_use_pc;
    w_in_ctrl.use_imm   = in_use_imm;
    w_in_ctrl.reg_write = in_reg_write;
  end

  fwd_select #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr_i    (in_rs1_addr),
    .reg_data_i   (in_rs1_data),
    .exmem_we_i   (exmem_we),
    .exmem_rd_i   (exmem_rd),
    .exmem_data_i (exmem_data),
    .memwb_we_i   (memwb_we),
    .memwb_rd_i   (memwb_rd),
    .memwb_data_i (memwb_data),
    .data_o       (w_cap_rs1)
  );

  fwd_select #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr_i    (in_rs2_addr),
    .reg_data_i   (in_rs2_data),
    .exmem_we_i   (exmem_we),
    .exmem_rd_i   (exmem_rd),
    .exmem_data_i (exmem_data),
    .memwb_we_i   (memwb_we),
    .memwb_rd_i   (memwb_rd),
    .memwb_data_i (memwb_data),
    .data_o       (w_cap_rs2)
  );

  // Held entries keep snooping MEM/WB so a late writeback is not missed.
  assign w_main_rs1_ref = fwd_hit(memwb_we, memwb_rd, main_ctrl_q.rs1_addr) ? memwb_data : main_rs1_q;
  assign w_main_rs2_ref = fwd_hit(memwb_we, memwb_rd, main_ctrl_q.rs2_addr) ? memwb_data : main_rs2_q;
  assign w_skid_rs1_ref = fwd_hit(memwb_we, memwb_rd, skid_ctrl_q.rs1_addr) ? memwb_data : skid_rs1_q;
  assign w_skid_rs2_ref = fwd_hit(memwb_we, memwb_rd, skid_ctrl_q.rs2_addr) ? memwb_data : skid_rs2_q;

  assign in_ready = ~skid_valid_q;
  assign w_accept = in_valid & ~skid_valid_q;
  assign w_drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_rs1_d   = w_main_rs1_ref;
    main_rs2_d   = w_main_rs2_ref;
    main_imm_d   = main_imm_q;
    main_pc_d    = main_pc_q;
    skid_rs1_d   = w_skid_rs1_ref;
    skid_rs2_d   = w_skid_rs2_ref;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || w_drain) begin
      // in_ready is low whenever skid is full, so promotion never races an accept.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        main_ctrl_d  = skid_ctrl_q;
        main_rs1_d   = w_skid_rs1_ref;
        main_rs2_d   = w_skid_rs2_ref;
        main_imm_d   = skid_imm_q;
        main_pc_d    = skid_pc_q;
      end else if (w_accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = w_in_ctrl;
        main_rs1_d   = w_cap_rs1;
        main_rs2_d   = w_cap_rs2;
        main_imm_d   = in_imm;
        main_pc_d    = in_pc;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = w_in_ctrl;
      skid_rs1_d   = w_cap_rs1;
      skid_rs2_d   = w_cap_rs2;
      skid_imm_d   = in_imm;
      skid_pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_rs1_q   <= '0;
      main_rs2_q   <= '0;
      main_imm_q   <= '0;
      main_pc_q    <= '0;
      skid_rs1_q   <= '0;
      skid_rs2_q   <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_rs1_q   <= main_rs1_d;
      main_rs2_q   <= main_rs2_d;
      main_imm_q   <= main_imm_d;
      main_pc_q    <= main_pc_d;
      skid_rs1_q   <= skid_rs1_d;
      skid_rs2_q   <= skid_rs2_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign srcA           = main_ctrl_q.use_pc  ? main_pc_q  : main_rs1_q;
  assign srcB           = main_ctrl_q.use_imm ? main_imm_q : main_rs2_q;
  assign out_store_data = main_rs2_q;
  assign alu_ctrl       = main_ctrl_q.alu_ctrl;
  assign out_rd_addr    = main_ctrl_q.rd_addr;
  assign out_reg_write  = main_ctrl_q.reg_write;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_operand_stage -- vector table, directed corner sequences, random run
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam int XLEN = 32;

  logic            clk, rst_n, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]      in_alu_ctrl;
  logic            in_use_pc, in_use_imm, in_reg_write;
  logic            exmem_we, memwb_we;
  logic [4:0]      exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_data, memwb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] srcA, srcB, out_store_data;
  logic [3:0]      alu_ctrl;
  logic [4:0]      out_rd_addr;
  logic            out_reg_write;

  alu_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_ctrl(in_alu_ctrl), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
    .in_reg_write(in_reg_write),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .srcA(srcA), .srcB(srcB), .out_store_data(out_store_data),
    .alu_ctrl(alu_ctrl), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid, flush, out_ready;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [3:0]  ctrl;
    logic        use_pc, use_imm, rw;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_d;
  } cin_t;

  typedef struct {
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1v, rs2v, imm, pc;
    logic [3:0]  ctrl;
    logic        use_pc, use_imm, rw;
  } ent_t;

  typedef struct {
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic        use_pc, use_imm;
    logic [3:0]  ctrl;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_d;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cin_t idle(input logic rdy);
    cin_t c;
    c = '{default: '0};
    c.out_ready = rdy;
    return c;
  endfunction

  function automatic cin_t entry(input logic rdy, input logic [4:0] r1, input logic [31:0] d1,
                                 input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd);
    cin_t c;
    c = idle(rdy);
    c.in_valid = 1'b1;
    c.rs1a = r1; c.rs1d = d1; c.rs2a = r2; c.rs2d = d2; c.rda = rd;
    c.ctrl = 4'h0; c.rw = 1'b1; c.imm = 32'h44; c.pc = 32'h800;
    return c;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regv, input cin_t c);
    if (rs != 0 && c.ex_we && c.ex_rd == rs) return c.ex_d;
    if (rs != 0 && c.mw_we && c.mw_rd == rs) return c.mw_d;
    return regv;
  endfunction

  task automatic drive(input cin_t c);
    in_valid = c.in_valid; flush = c.flush; out_ready = c.out_ready;
    in_rs1_addr = c.rs1a; in_rs2_addr = c.rs2a; in_rd_addr = c.rda;
    in_rs1_data = c.rs1d; in_rs2_data = c.rs2d; in_imm = c.imm; in_pc = c.pc;
    in_alu_ctrl = c.ctrl; in_use_pc = c.use_pc; in_use_imm = c.use_imm; in_reg_write = c.rw;
    exmem_we = c.ex_we; exmem_rd = c.ex_rd; exmem_data = c.ex_d;
    memwb_we = c.mw_we; memwb_rd = c.mw_rd; memwb_data = c.mw_d;
  endtask

  // Model: a FIFO of at most two pending instructions, oldest at the front.
  task automatic check_model();
    ent_t e;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      chk("srcA", srcA, e.use_pc ? e.pc : e.rs1v);
      chk("srcB", srcB, e.use_imm ? e.imm : e.rs2v);
      chk("store_data", out_store_data, e.rs2v);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
      chk("rd_addr", 32'(out_rd_addr), 32'(e.rda));
      chk("reg_write", 32'(out_reg_write), 32'(e.rw));
    end
  endtask

  task automatic model_edge(input cin_t c);
    int   sz;
    ent_t e;
    sz = q.size();
    if (c.flush) begin
      q.delete();
    end else begin
      if (sz > 0 && c.out_ready) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (e.rs1a != 0 && c.mw_we && c.mw_rd == e.rs1a) e.rs1v = c.mw_d;
        if (e.rs2a != 0 && c.mw_we && c.mw_rd == e.rs2a) e.rs2v = c.mw_d;
        q[i] = e;
      end
      if (c.in_valid && sz < 2) begin
        e.rs1a = c.rs1a; e.rs2a = c.rs2a; e.rda = c.rda;
        e.rs1v = fwd(c.rs1a, c.rs1d, c); e.rs2v = fwd(c.rs2a, c.rs2d, c);
        e.imm = c.imm; e.pc = c.pc; e.ctrl = c.ctrl;
        e.use_pc = c.use_pc; e.use_imm = c.use_imm; e.rw = c.rw;
        q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input cin_t c);
    drive(c);
    check_model();
    @(posedge clk);
    model_edge(c);
    @(negedge clk);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_srcA"}, srcA, 32'd0);
    chk({tag, "_srcB"}, srcB, 32'd0);
    chk({tag, "_store"}, out_store_data, 32'd0);
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, "_rd"}, 32'(out_rd_addr), 32'd0);
    chk({tag, "_rw"}, 32'(out_reg_write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    cin_t c;

    vecs[0] = '{5'd5, 5'd6, 32'h10, 32'h20, 32'h99, 32'h1000, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    32'h10,   32'h20,  32'h20};
    vecs[1] = '{5'd5, 5'd6, 32'h10, 32'h20, 32'h99, 32'h1000, 1'b0, 1'b0, 4'h1, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'h20,  32'h20};
    vecs[2] = '{5'd0, 5'd6, 32'h10, 32'h20, 32'h99, 32'h1000, 1'b0, 1'b0, 4'h2, 1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 32'h10,   32'h20,  32'h20};
    vecs[3] = '{5'd5, 5'd6, 32'h10, 32'h20, 32'h99, 32'h1000, 1'b0, 1'b0, 4'h3, 1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 32'hBBBB, 32'h10,   32'hBBBB, 32'hBBBB};
    vecs[4] = '{5'd5, 5'd6, 32'h10, 32'h20, 32'h7FF, 32'h2000, 1'b1, 1'b1, 4'hF, 1'b1, 5'd6, 32'hCCCC, 1'b0, 5'd0, 32'h0,   32'h2000, 32'h7FF, 32'hCCCC};
    vecs[5] = '{5'd5, 5'd6, 32'h10, 32'h20, 32'h99, 32'h1000, 1'b0, 1'b0, 4'hA, 1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hBBBB, 32'h20,  32'h20};
    vecs[6] = '{5'd3, 5'd3, 32'h30, 32'h30, 32'h99, 32'h1000, 1'b0, 1'b0, 4'h7, 1'b1, 5'd3, 32'h55,   1'b1, 5'd3, 32'h66,   32'h55,   32'h55,  32'h55};
    vecs[7] = '{5'd4, 5'd6, 32'h40, 32'h20, 32'h99, 32'h1000, 1'b0, 1'b0, 4'h9, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd4, 32'hDDDD, 32'hDDDD, 32'h20,  32'h20};

    drive(idle(1'b0));
    rst_n = 1'b0;
    #2;
    reset_chk("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Capture-time forwarding vectors, one instruction at a time.
    for (int i = 0; i < 8; i++) begin
      c = idle(1'b1);
      c.in_valid = 1'b1; c.rda = 5'd9; c.rw = 1'b1;
      c.rs1a = vecs[i].rs1a; c.rs2a = vecs[i].rs2a;
      c.rs1d = vecs[i].rs1d; c.rs2d = vecs[i].rs2d;
      c.imm = vecs[i].imm; c.pc = vecs[i].pc;
      c.use_pc = vecs[i].use_pc; c.use_imm = vecs[i].use_imm; c.ctrl = vecs[i].ctrl;
      c.ex_we = vecs[i].ex_we; c.ex_rd = vecs[i].ex_rd; c.ex_d = vecs[i].ex_d;
      c.mw_we = vecs[i].mw_we; c.mw_rd = vecs[i].mw_rd; c.mw_d = vecs[i].mw_d;
      cycle(c);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_srcA", i), srcA, vecs[i].exp_a);
      chk($sformatf("vec%0d_srcB", i), srcB, vecs[i].exp_b);
      chk($sformatf("vec%0d_store", i), out_store_data, vecs[i].exp_st);
      chk($sformatf("vec%0d_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
      cycle(idle(1'b1));
    end

    // Stall: two entries fill main and skid, a third is refused, order preserved.
    cycle(entry(1'b0, 5'd1, 32'h111, 5'd2, 32'h1, 5'd10));
    cycle(entry(1'b0, 5'd2, 32'h222, 5'd2, 32'h2, 5'd11));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    cycle(entry(1'b0, 5'd3, 32'h333, 5'd2, 32'h3, 5'd12));
    chk("stall_hold_valid", 32'(out_valid), 32'd1);
    chk("stall_hold_srcA", srcA, 32'h111);
    cycle(idle(1'b1));
    chk("stall_second_srcA", srcA, 32'h222);
    chk("stall_ready_back", 32'(in_ready), 32'd1);
    cycle(idle(1'b1));
    chk("stall_empty", 32'(out_valid), 32'd0);

    // Late MEM/WB writeback refreshes a held entry.
    cycle(entry(1'b0, 5'd1, 32'h1, 5'd7, 32'h5, 5'd13));
    c = idle(1'b0);
    c.mw_we = 1'b1; c.mw_rd = 5'd7; c.mw_d = 32'h1234;
    cycle(c);
    chk("refresh_srcB", srcB, 32'h1234);
    chk("refresh_store", out_store_data, 32'h1234);
    cycle(idle(1'b1));

    // Flush with both entries full and a new offer.
    cycle(entry(1'b0, 5'd1, 32'hA1, 5'd2, 32'hB1, 5'd14));
    cycle(entry(1'b0, 5'd1, 32'hA2, 5'd2, 32'hB2, 5'd15));
    c = entry(1'b0, 5'd1, 32'hA3, 5'd2, 32'hB3, 5'd16);
    c.flush = 1'b1;
    cycle(c);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(idle(1'b1));

    // Asynchronous reset in the middle of a stall.
    cycle(entry(1'b0, 5'd1, 32'hC1, 5'd2, 32'hD1, 5'd17));
    cycle(entry(1'b0, 5'd1, 32'hC2, 5'd2, 32'hD2, 5'd18));
    drive(idle(1'b0));
    @(posedge clk);
    model_edge(idle(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    reset_chk("async");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the FIFO model.
    for (int n = 0; n < 400; n++) begin
      c = idle(1'($urandom_range(0, 9) < 6));
      c.in_valid = 1'($urandom_range(0, 9) < 6);
      c.flush    = 1'($urandom_range(0, 31) == 0);
      c.rs1a = 5'($urandom_range(0, 7)); c.rs2a = 5'($urandom_range(0, 7));
      c.rda  = 5'($urandom_range(0, 31));
      c.rs1d = $urandom; c.rs2d = $urandom; c.imm = $urandom; c.pc = $urandom;
      c.ctrl = 4'($urandom_range(0, 15));
      c.use_pc = 1'($urandom_range(0, 1)); c.use_imm = 1'($urandom_range(0, 1));
      c.rw = 1'($urandom_range(0, 1));
      c.ex_we = 1'($urandom_range(0, 1)); c.ex_rd = 5'($urandom_range(0, 7)); c.ex_d = $urandom;
      c.mw_we = 1'($urandom_range(0, 1)); c.mw_rd = 5'($urandom_range(0, 7)); c.mw_d = $urandom;
      cycle(c);
    end
    for (int n = 0; n < 3; n++) cycle(idle(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
